// File: rtl/nvram_upload_reader.sv
// HPS ioctl upload reader: returns NVRAM bytes on ioctl_din, stalling the HPS with ioctl_wait.
// Optional NVRAM_DIRTY_EN tracks whether NVRAM changed since the last complete save.
module nvram_upload_reader #(
    parameter int ADDR_W       = 8,
    parameter int UPLOAD_INDEX = 4,
    parameter int RAM_LAT      = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] nv_addr,
    output logic              nv_rd,
    input  logic              nv_busy,
    input  logic [7:0]        nv_q,
    output logic              active,
    input  logic              cpu_we,
    output logic              nv_dirty
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              active_q;
    logic              sel_s;
    logic              in_range_s;
    logic              cap_s;

    assign sel_s      = ioctl_upload && (ioctl_index == 8'(UPLOAD_INDEX));
    // The range check looks at every address bit so high addresses never alias into the image.
    assign in_range_s = ((ioctl_addr >> ADDR_W) == 25'd0);

    // Transfer FSM next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        cap_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ioctl_rd && sel_s) begin
                    wait_d = 1'b1;
                    if (in_range_s) begin
                        addr_d  = ioctl_addr[ADDR_W-1:0];
                        rd_d    = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        din_d   = 8'hFF;
                        state_d = S_DONE;
                    end
                end else begin
                    wait_d = 1'b0;
                    rd_d   = 1'b0;
                end
            end
            S_REQ: begin
                if (!sel_s) begin
                    wait_d  = 1'b0;
                    rd_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (!nv_busy) begin
                    rd_d    = 1'b0;
                    cnt_d   = 3'(RAM_LAT - 1);
                    state_d = S_WAIT;
                end else begin
                    rd_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!sel_s) begin
                    wait_d  = 1'b0;
                    rd_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    din_d   = nv_q;
                    wait_d  = 1'b0;
                    cap_s   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                wait_d  = 1'b0;
                rd_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                wait_d  = 1'b0;
                rd_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Transfer FSM and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            din_q    <= 8'h00;
            wait_q   <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            cnt_q    <= 3'd0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            active_q <= sel_s;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign nv_rd      = rd_q;
    assign nv_addr    = addr_q;
    assign active     = active_q;

`ifdef NVRAM_DIRTY_EN
    logic dirty_q, dirty_d;
    logic saw_rd_q, saw_rd_d;
    logic we_seen_q, we_seen_d;
    logic last_q, last_d;
    logic sel_fall_s;

    assign sel_fall_s = active_q && !sel_s;

    // Dirty flag and per-upload bookkeeping; a CPU write always wins over a clear.
    always_comb begin
        dirty_d   = dirty_q;
        saw_rd_d  = saw_rd_q;
        we_seen_d = we_seen_q;
        last_d    = last_q;
        if (cpu_we) begin
            dirty_d = 1'b1;
        end else if (sel_fall_s && last_q && !we_seen_q) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
        if (!sel_s) begin
            saw_rd_d  = 1'b0;
            we_seen_d = 1'b0;
            last_d    = 1'b0;
        end else begin
            if (ioctl_rd && (state_q == S_IDLE) && !saw_rd_q) begin
                saw_rd_d  = 1'b1;
                we_seen_d = cpu_we;
            end else if (cpu_we) begin
                we_seen_d = 1'b1;
            end else begin
                we_seen_d = we_seen_q;
            end
            if (cap_s && (addr_q == ADDR_MAX)) begin
                last_d = 1'b1;
            end else begin
                last_d = last_q;
            end
        end
    end

    // Dirty tracking registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty_q   <= 1'b0;
            saw_rd_q  <= 1'b0;
            we_seen_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            dirty_q   <= dirty_d;
            saw_rd_q  <= saw_rd_d;
            we_seen_q <= we_seen_d;
            last_q    <= last_d;
        end
    end

    assign nv_dirty = dirty_q;
`else
    logic unused_s;
    assign unused_s = &{1'b0, cpu_we, cap_s};
    assign nv_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench for nvram_upload_reader with a latency-accurate NVRAM model.
// Dirty-flag checks compile in only when NVRAM_DIRTY_EN is defined.
module tb_nvram_upload_reader;

    localparam int ADDR_W  = 8;
    localparam int RAM_LAT = 2;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              ioctl_upload = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic              ioctl_rd = 1'b0;
    logic [24:0]       ioctl_addr = 25'd0;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] nv_addr;
    logic              nv_rd;
    logic              nv_busy = 1'b0;
    logic [7:0]        nv_q;
    logic              active;
    logic              cpu_we = 1'b0;
    logic              nv_dirty;

    logic [7:0] mem [256];
    logic [7:0] pipe [RAM_LAT];

    int n_vec = 0;
    int n_err = 0;

    nvram_upload_reader #(.ADDR_W(ADDR_W), .UPLOAD_INDEX(4), .RAM_LAT(RAM_LAT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .nv_addr(nv_addr),
        .nv_rd(nv_rd), .nv_busy(nv_busy), .nv_q(nv_q), .active(active),
        .cpu_we(cpu_we), .nv_dirty(nv_dirty)
    );

    always #5 clk_sys = ~clk_sys;

    // NVRAM model: data appears exactly RAM_LAT cycles after an accepted read, garbage otherwise.
    always @(posedge clk_sys) begin
        pipe[0] <= (nv_rd && !nv_busy) ? mem[nv_addr] : 8'hEE;
        for (int k = 1; k < RAM_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign nv_q = pipe[RAM_LAT-1];

    function automatic logic [7:0] exp_byte(input int a);
        logic [7:0] v;
        v = 8'((a * 7) + 3);
        if (a == 16) v = 8'h5A;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Issue one read, hold nv_busy for the first 'busy' cycles, measure the stall.
    task automatic do_read(input logic [24:0] addr, input int busy, output logic [7:0] data,
                           output int wcyc, output int rd_tot, output int rd_busy);
        wcyc = 0; rd_tot = 0; rd_busy = 0;
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            nv_busy = (cyc <= busy);
            #0;
            if (!ioctl_wait) break;
            wcyc++;
            if (nv_rd) rd_tot++;
            if (nv_rd && nv_busy) rd_busy++;
            tick();
        end
        nv_busy = 1'b0;
        data = ioctl_din;
        tick();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] prev;
        int w, rt, rb, bad, seen;

        for (int i = 0; i < 256; i++) mem[i] = exp_byte(i);

        // Reset state
        tick(); tick();
        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_wait", ioctl_wait, 1'b0);
        chk("rst_nv_rd", nv_rd, 1'b0);
        chk("rst_nv_addr", nv_addr, 8'h00);
        chk("rst_active", active, 1'b0);
        chk("rst_dirty", nv_dirty, 1'b0);

        reset_n = 1'b1;
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd4;
        tick();
        chk("active_on", active, 1'b1);

        // Basic read
        do_read(25'h10, 0, d, w, rt, rb);
        chk("basic_wait_cycles", w, 3);
        chk("basic_din", d, 8'h5A);
        chk("basic_rd_cycles", rt, 1);
        chk("basic_nv_addr", nv_addr, 8'h10);

        // Contention: busy for three cycles after rd
        do_read(25'h80, 3, d, w, rt, rb);
        chk("busy_wait_cycles", w, 6);
        chk("busy_rd_held", rb, 3);
        chk("busy_din", d, exp_byte(128));

        // Out of range, including a high address whose low bits would alias
        do_read(25'h100, 0, d, w, rt, rb);
        chk("oor_wait_cycles", w, 1);
        chk("oor_rd_cycles", rt, 0);
        chk("oor_din", d, 8'hFF);
        do_read(25'h10010, 0, d, w, rt, rb);
        chk("oor_alias_rd", rt, 0);
        chk("oor_alias_din", d, 8'hFF);

        // Top address of the image
        do_read(25'hFF, 0, d, w, rt, rb);
        chk("top_din", d, exp_byte(255));
        chk("top_wait_cycles", w, 3);

        // Wrong index: no response
        prev = exp_byte(255);
        ioctl_index = 8'd0;
        tick();
        chk("wrongidx_active", active, 1'b0);
        ioctl_addr = 25'h20; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ioctl_wait || nv_rd) seen++;
            tick();
        end
        chk("wrongidx_no_resp", seen, 0);
        chk("wrongidx_din", ioctl_din, prev);

        // Abort: upload drops while in WAIT
        ioctl_index = 8'd4;
        tick();
        ioctl_addr = 25'h30; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        chk("abort_pre_wait", ioctl_wait, 1'b1);
        ioctl_upload = 1'b0;
        tick();
        chk("abort_wait", ioctl_wait, 1'b0);
        chk("abort_nv_rd", nv_rd, 1'b0);
        chk("abort_din", ioctl_din, prev);
        ioctl_upload = 1'b1;
        tick(); tick(); tick();
        chk("abort_din_later", ioctl_din, prev);

        // Asynchronous reset mid-WAIT
        ioctl_addr = 25'h40; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_wait", ioctl_wait, 1'b0);
        chk("async_rst_din", ioctl_din, 8'h00);
        chk("async_rst_nv_addr", nv_addr, 8'h00);
        chk("async_rst_active", active, 1'b0);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        do_read(25'h41, 0, d, w, rt, rb);
        chk("post_rst_wait_cycles", w, 3);
        chk("post_rst_din", d, exp_byte(65));
        chk("dirty_default", nv_dirty, 1'b0);

`ifdef NVRAM_DIRTY_EN
        cpu_we = 1'b1; tick(); cpu_we = 1'b0; tick();
        chk("dirty_set", nv_dirty, 1'b1);
        ioctl_upload = 1'b0; tick(); tick();
        ioctl_upload = 1'b1; tick();
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            do_read(25'(a), 0, d, w, rt, rb);
            if (d !== exp_byte(a)) bad++;
        end
        chk("full_upload_data", bad, 0);
        chk("dirty_during_upload", nv_dirty, 1'b1);
        ioctl_upload = 1'b0;
        tick();
        chk("dirty_cleared", nv_dirty, 1'b0);
        tick();
        cpu_we = 1'b1; tick(); cpu_we = 1'b0; tick();
        chk("dirty_set2", nv_dirty, 1'b1);
        ioctl_upload = 1'b1; tick();
        for (int a = 0; a < 256; a++) begin
            if (a == 100) begin cpu_we = 1'b1; tick(); cpu_we = 1'b0; end
            do_read(25'(a), 0, d, w, rt, rb);
        end
        ioctl_upload = 1'b0;
        tick(); tick();
        chk("dirty_kept_on_write", nv_dirty, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
